// File: rtl/seven_segment_pkg.sv
// Shared definitions for the multiplexed seven-segment scanner: the
// abc_defg segment ordering, the active-low glyph constants and a width helper.
package seven_segment_pkg;

  // Packed so that field a lands on bit 6 and field g on bit 0.
  typedef struct packed {
    logic a;
    logic b;
    logic c;
    logic d;
    logic e;
    logic f;
    logic g;
  } glyph_t;

  // Active-low glyphs: a 0 lights the segment.
  localparam glyph_t GLYPH_0     = 7'b0000001;
  localparam glyph_t GLYPH_1     = 7'b1001111;
  localparam glyph_t GLYPH_2     = 7'b0010010;
  localparam glyph_t GLYPH_3     = 7'b0000110;
  localparam glyph_t GLYPH_4     = 7'b1001100;
  localparam glyph_t GLYPH_5     = 7'b0100100;
  localparam glyph_t GLYPH_6     = 7'b0100000;
  localparam glyph_t GLYPH_7     = 7'b0001111;
  localparam glyph_t GLYPH_8     = 7'b0000000;
  localparam glyph_t GLYPH_9     = 7'b0001100;
  localparam glyph_t GLYPH_A     = 7'b0001000;
  localparam glyph_t GLYPH_B     = 7'b1100000;
  localparam glyph_t GLYPH_C     = 7'b0110001;
  localparam glyph_t GLYPH_D     = 7'b1000010;
  localparam glyph_t GLYPH_E     = 7'b0110000;
  localparam glyph_t GLYPH_F     = 7'b0111000;
  localparam glyph_t GLYPH_BLANK = 7'b1111111;

  // Counter width for a modulus n; a modulus of 1 still needs one bit.
  function automatic int widthOf(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seven_segment_glyph.sv
// Combinational nibble-to-glyph decoder. Hex letters are shown only when
// hexEn_i is set; otherwise 10..15 render as a dark digit.
module seven_segment_glyph
  import seven_segment_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       hexEn_i,
  output glyph_t     glyph_o
);

  // Map each nibble onto its glyph, defaulting to blank.
  always_comb begin
    glyph_o = GLYPH_BLANK;
    case (nibble_i)
      4'h0: glyph_o = GLYPH_0;
      4'h1: glyph_o = GLYPH_1;
      4'h2: glyph_o = GLYPH_2;
      4'h3: glyph_o = GLYPH_3;
      4'h4: glyph_o = GLYPH_4;
      4'h5: glyph_o = GLYPH_5;
      4'h6: glyph_o = GLYPH_6;
      4'h7: glyph_o = GLYPH_7;
      4'h8: glyph_o = GLYPH_8;
      4'h9: glyph_o = GLYPH_9;
      4'hA: glyph_o = hexEn_i ? GLYPH_A : GLYPH_BLANK;
      4'hB: glyph_o = hexEn_i ? GLYPH_B : GLYPH_BLANK;
      4'hC: glyph_o = hexEn_i ? GLYPH_C : GLYPH_BLANK;
      4'hD: glyph_o = hexEn_i ? GLYPH_D : GLYPH_BLANK;
      4'hE: glyph_o = hexEn_i ? GLYPH_E : GLYPH_BLANK;
      4'hF: glyph_o = hexEn_i ? GLYPH_F : GLYPH_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_segment_scanner.sv
// Multiplexed seven-segment scanner with a double-buffered value. Loads land
// in a back buffer and are promoted to the displayed front buffer only when a
// full scan completes, so a frame never mixes old and new digits.
module seven_segment_scanner
  import seven_segment_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
)
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    hex_en,
  input  logic                    blank_lz,
  output logic [6:0]              segments,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   anode_n,
  output logic                    frame_done
);

  localparam int PW = widthOf(REFRESH_DIV);
  localparam int IW = widthOf(NUM_DIGITS);
  localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]           prescale_q,   prescale_d;
  logic [IW-1:0]           index_q,      index_d;
  logic [4*NUM_DIGITS-1:0] backValue_q,  backValue_d;
  logic [NUM_DIGITS-1:0]   backDp_q,     backDp_d;
  logic [4*NUM_DIGITS-1:0] frontValue_q, frontValue_d;
  logic [NUM_DIGITS-1:0]   frontDp_q,    frontDp_d;
  logic                    pending_q,    pending_d;
  logic                    frameDone_q,  frameDone_d;
  glyph_t                  segments_q,   segments_d;
  logic                    dpN_q,        dpN_d;
  logic [NUM_DIGITS-1:0]   anodeN_q,     anodeN_d;

  logic                    boundary;
  logic [3:0]              selNibble;
  logic                    selDp;
  logic                    anyNonZero;
  logic                    zeroBlank;
  glyph_t                  decoded;

  // Scan timing and buffer handoff: the prescaler paces the digit index, and
  // the wrap of the last digit back to 0 is the only point the front buffer moves.
  always_comb begin
    prescale_d = prescale_q + PW'(1);
    index_d    = index_q;
    boundary   = 1'b0;
    if (prescale_q == PRE_LAST) begin
      prescale_d = '0;
      if (index_q == IDX_LAST) begin
        index_d  = '0;
        boundary = 1'b1;
      end else begin
        index_d  = index_q + IW'(1);
      end
    end
    backValue_d  = load ? value : backValue_q;
    backDp_d     = load ? dp_in : backDp_q;
    frontValue_d = (boundary && pending_q) ? backValue_q : frontValue_q;
    frontDp_d    = (boundary && pending_q) ? backDp_q    : frontDp_q;
    pending_d    = load | (pending_q & ~boundary);
    frameDone_d  = boundary;
  end

  // Select the active digit from the front buffer, build the one-cold anode
  // pattern, and decide whether this digit is a leading zero to suppress.
  always_comb begin
    selNibble  = 4'h0;
    selDp      = 1'b0;
    anyNonZero = 1'b0;
    anodeN_d   = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (index_q == IW'(k)) begin
        selNibble   = frontValue_q[4*k +: 4];
        selDp       = frontDp_q[k];
        anodeN_d[k] = 1'b0;
      end
      if ((IW'(k) >= index_q) && (frontValue_q[4*k +: 4] != 4'h0)) begin
        anyNonZero = 1'b1;
      end
    end
    zeroBlank  = blank_lz && (index_q != '0) && !anyNonZero;
    segments_d = zeroBlank ? GLYPH_BLANK : decoded;
    dpN_d      = ~selDp;
  end

  seven_segment_glyph u_glyph (
    .nibble_i (selNibble),
    .hexEn_i  (hex_en),
    .glyph_o  (decoded)
  );

  // State and output registers; reset wins over a same-cycle load.
  always_ff @(posedge clk) begin
    if (reset) begin
      prescale_q   <= '0;
      index_q      <= '0;
      backValue_q  <= '0;
      backDp_q     <= '0;
      frontValue_q <= '0;
      frontDp_q    <= '0;
      pending_q    <= 1'b0;
      frameDone_q  <= 1'b0;
      segments_q   <= GLYPH_BLANK;
      dpN_q        <= 1'b1;
      anodeN_q     <= '1;
    end else begin
      prescale_q   <= prescale_d;
      index_q      <= index_d;
      backValue_q  <= backValue_d;
      backDp_q     <= backDp_d;
      frontValue_q <= frontValue_d;
      frontDp_q    <= frontDp_d;
      pending_q    <= pending_d;
      frameDone_q  <= frameDone_d;
      segments_q   <= segments_d;
      dpN_q        <= dpN_d;
      anodeN_q     <= anodeN_d;
    end
  end

  assign segments   = segments_q;
  assign dp_n       = dpN_q;
  assign anode_n    = anodeN_q;
  assign frame_done = frameDone_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Self-checking bench for the seven-segment scanner with four digits and a
// two-cycle refresh. Expected outputs are pushed to a queue before each clock
// edge and popped for comparison once the registered outputs have settled.
module tb_seven_segment_scanner;

  localparam int ND = 4;
  localparam int RD = 2;

  logic        clk;
  logic        reset;
  logic [15:0] value;
  logic        load;
  logic [3:0]  dp_in;
  logic        hex_en;
  logic        blank_lz;
  logic [6:0]  segments;
  logic        dp_n;
  logic [3:0]  anode_n;
  logic        frame_done;

  typedef struct {
    logic [3:0] anode;
    logic [6:0] segs;
    logic       dp;
    logic       fd;
  } sbEntry_t;

  sbEntry_t    sbQueue[$];
  int          total = 0;
  int          bad   = 0;

  int          n;
  logic [15:0] mBack;
  logic [15:0] mFront;
  logic [3:0]  mBackDp;
  logic [3:0]  mFrontDp;
  logic        mPending;

  seven_segment_scanner #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .value      (value),
    .load       (load),
    .dp_in      (dp_in),
    .hex_en     (hex_en),
    .blank_lz   (blank_lz),
    .segments   (segments),
    .dp_n       (dp_n),
    .anode_n    (anode_n),
    .frame_done (frame_done)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference glyph for digit d of v, applying hex and leading-zero rules.
  function automatic logic [6:0] refGlyph(input logic [15:0] v, input int d,
                                          input logic hex, input logic blz);
    logic [15:0] upper;
    logic [3:0]  nib;
    logic [6:0]  g;
    upper = v >> (4 * d);
    nib   = upper[3:0];
    if (blz && d >= 1 && upper == 16'h0) return 7'b1111111;
    case (nib)
      4'h0: g = 7'b0000001;
      4'h1: g = 7'b1001111;
      4'h2: g = 7'b0010010;
      4'h3: g = 7'b0000110;
      4'h4: g = 7'b1001100;
      4'h5: g = 7'b0100100;
      4'h6: g = 7'b0100000;
      4'h7: g = 7'b0001111;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0001100;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b1100000;
      4'hC: g = 7'b0110001;
      4'hD: g = 7'b1000010;
      4'hE: g = 7'b0110000;
      default: g = 7'b0111000;
    endcase
    if (nib >= 4'hA && !hex) g = 7'b1111111;
    return g;
  endfunction

  // Pop the oldest expectation and compare it with the settled outputs.
  task automatic checkOutput();
    sbEntry_t e;
    total++;
    assert (sbQueue.size() != 0) else begin
      bad++;
      $error("[TB] FAIL scoreboard_empty at n=%0d: got no entry, need one", n);
    end
    if (sbQueue.size() != 0) begin
      e = sbQueue.pop_front();
      total++;
      assert (anode_n === e.anode) else begin
        bad++;
        $error("[TB] FAIL anode_n at n=%0d: got %b expected %b", n, anode_n, e.anode);
      end
      total++;
      assert (segments === e.segs) else begin
        bad++;
        $error("[TB] FAIL segments at n=%0d: got %b expected %b", n, segments, e.segs);
      end
      total++;
      assert (dp_n === e.dp) else begin
        bad++;
        $error("[TB] FAIL dp_n at n=%0d: got %b expected %b", n, dp_n, e.dp);
      end
      total++;
      assert (frame_done === e.fd) else begin
        bad++;
        $error("[TB] FAIL frame_done at n=%0d: got %b expected %b", n, frame_done, e.fd);
      end
    end
  endtask

  // One clock: predict outputs from the model, advance the model with the
  // inputs present at this edge, then let the edge happen and check.
  task automatic tick();
    sbEntry_t e;
    int       d;
    logic     bnd;
    if (reset) begin
      e.anode = 4'b1111;
      e.segs  = 7'b1111111;
      e.dp    = 1'b1;
      e.fd    = 1'b0;
      sbQueue.push_back(e);
      n        = 0;
      mBack    = '0;
      mFront   = '0;
      mBackDp  = '0;
      mFrontDp = '0;
      mPending = 1'b0;
    end else begin
      n++;
      d       = ((n - 1) / 2) % 4;
      bnd     = (n % 8) == 0;
      e.anode = ~(4'b0001 << d);
      e.segs  = refGlyph(mFront, d, hex_en, blank_lz);
      e.dp    = ~mFrontDp[d];
      e.fd    = bnd;
      sbQueue.push_back(e);
      if (bnd && mPending) begin
        mFront   = mBack;
        mFrontDp = mBackDp;
      end
      if (load) begin
        mBack    = value;
        mBackDp  = dp_in;
        mPending = 1'b1;
      end else if (bnd) begin
        mPending = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  // Present a one-cycle load strobe with the given value and decimal points.
  task automatic applyStimulus(input logic [15:0] v, input logic [3:0] dp);
    value = v;
    dp_in = dp;
    load  = 1'b1;
    tick();
    load  = 1'b0;
  endtask

  task automatic runCycles(input int c);
    for (int i = 0; i < c; i++) tick();
  endtask

  // Advance until the edge count sits at a given phase within the 8-cycle frame.
  task automatic waitPhase(input int p);
    for (int i = 0; i < 8 && (n % 8) != p; i++) tick();
  endtask

  // Directed sequence of scenarios.
  initial begin
    reset    = 1'b1;
    load     = 1'b0;
    value    = '0;
    dp_in    = '0;
    hex_en   = 1'b1;
    blank_lz = 1'b0;
    n        = 0;
    runCycles(3);
    reset = 1'b0;

    // Plain scan of an all-zero display over two frames.
    runCycles(16);

    // Mid-frame load must wait for the next frame boundary.
    runCycles(3);
    applyStimulus(16'h1234, 4'b0000);
    runCycles(20);

    // Leading-zero blanking on and off.
    blank_lz = 1'b1;
    applyStimulus(16'h0050, 4'b0000);
    runCycles(16);
    blank_lz = 1'b0;
    runCycles(8);

    // Hex letters, then the same digits with hex disabled.
    applyStimulus(16'hABCD, 4'b0000);
    runCycles(16);
    hex_en = 1'b0;
    runCycles(8);
    hex_en = 1'b1;

    // Remaining decimal glyphs.
    applyStimulus(16'h5678, 4'b0001);
    runCycles(16);

    // Load on the wrap cycle while an earlier load is still pending.
    waitPhase(3);
    applyStimulus(16'h4321, 4'b1000);
    waitPhase(7);
    applyStimulus(16'h9999, 4'b0100);
    runCycles(24);

    // Reset at index 2 with a competing load that must be discarded.
    waitPhase(4);
    reset = 1'b1;
    value = 16'hFFFF;
    dp_in = 4'b1111;
    load  = 1'b1;
    tick();
    reset = 1'b0;
    load  = 1'b0;
    runCycles(16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
